// File: rtl/coeff_rom_seq_if.sv
// coeff_rom_seq_if: start/stream/write bundle for the coefficient store sequencer
interface coeff_rom_seq_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              start;
  logic [ADDR_W:0]   term_cnt;
  logic              desc;
  logic              coeff_ready;
  logic              coeff_valid;
  logic [DATA_W-1:0] coeff_data;
  logic [ADDR_W-1:0] coeff_idx;
  logic              coeff_last;
  logic              busy;
  logic              done;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_err;
  modport master (
    output start, term_cnt, desc, coeff_ready, wr_en, wr_addr, wr_data,
    input  coeff_valid, coeff_data, coeff_idx, coeff_last, busy, done, wr_err
  );
  modport slave (
    input  start, term_cnt, desc, coeff_ready, wr_en, wr_addr, wr_data,
    output coeff_valid, coeff_data, coeff_idx, coeff_last, busy, done, wr_err
  );
endinterface

// File: rtl/coeff_rom_seq.sv
// coeff_rom_seq: writable coefficient table streaming the first N entries up or down
module coeff_rom_seq #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input logic            clk,
  input logic            rst,
  coeff_rom_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  typedef logic [DATA_W-1:0] tab_t [DEPTH];
  localparam logic [15:0] INIT [8] = '{16'h7FFF, 16'hC000, 16'h2AAA, 16'hA000,
                                       16'h1999, 16'h1555, 16'h1249, 16'h1000};
  function automatic tab_t init_tab();
    tab_t t;
    for (int i = 0; i < DEPTH; i++) t[i] = i < 8 ? DATA_W'(INIT[i]) : '0;
    return t;
  endfunction
  // Table is not touched by rst; its power-up image comes from the declaration.
  tab_t mem_q = init_tab();
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, end_q, end_d;
  logic              desc_q, desc_d, wr_err_q, wr_ok, last;
  logic [ADDR_W:0]   n;
  assign n     = bus.term_cnt > (ADDR_W+1)'(DEPTH) ? (ADDR_W+1)'(DEPTH) : bus.term_cnt;
  assign wr_ok = bus.wr_en && state_q == IDLE && {1'b0, bus.wr_addr} < (ADDR_W+1)'(DEPTH);
  assign last  = state_q == STREAM && idx_q == end_q;
  always_ff @(posedge clk) if (wr_ok) mem_q[bus.wr_addr] <= bus.wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      end_q    <= '0;
      desc_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      end_q    <= end_d;
      desc_q   <= desc_d;
      wr_err_q <= bus.wr_en && !wr_ok;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    end_d   = end_q;
    desc_d  = desc_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = n == 0 ? DONE : STREAM;
        idx_d   = bus.desc ? ADDR_W'(n - 1'b1) : '0;
        end_d   = bus.desc ? '0 : ADDR_W'(n - 1'b1);
        desc_d  = bus.desc;
      end
      STREAM: if (bus.coeff_ready) begin
        state_d = last ? DONE : STREAM;
        idx_d   = last ? idx_q : desc_q ? idx_q - 1'b1 : idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // Data is read live from the table so a write committed with start is visible.
  assign bus.coeff_valid = state_q == STREAM;
  assign bus.coeff_data  = bus.coeff_valid ? mem_q[idx_q] : '0;
  assign bus.coeff_idx   = idx_q;
  assign bus.coeff_last  = last;
  assign bus.busy        = state_q != IDLE;
  assign bus.done        = state_q == DONE;
  assign bus.wr_err      = wr_err_q;
endmodule

// File: tb/tb_coeff_rom_seq.sv
// tb_coeff_rom_seq: randomized scoreboard bench for coeff_rom_seq
module tb_coeff_rom_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  coeff_rom_seq_if #(.DATA_W(16), .ADDR_W(3)) bus ();
  coeff_rom_seq #(.DATA_W(16), .DEPTH(8), .ADDR_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {logic [15:0] d; logic [2:0] i; logic l;} beat_t;
  beat_t       sb[$];
  logic [15:0] mdl[8];
  int          checks = 0, fails = 0, done_cnt = 0, rdy_mode = 0, pat = 0;
  logic        hold_v = 1'b0;
  logic [15:0] hold_d;
  logic [2:0]  hold_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: bus.coeff_ready = 1'b1;
      1: bus.coeff_ready = 1'($urandom_range(0, 1));
      2: begin bus.coeff_ready = (pat % 4 == 0) || (pat % 4 == 3); pat++; end
      default: bus.coeff_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (hold_v && bus.coeff_valid === 1'b1) begin
      chk("stall_data", 32'(bus.coeff_data), 32'(hold_d));
      chk("stall_idx", 32'(bus.coeff_idx), 32'(hold_i));
    end
    hold_v = bus.coeff_valid === 1'b1 && bus.coeff_ready !== 1'b1;
    hold_d = bus.coeff_data;
    hold_i = bus.coeff_idx;
    if (bus.coeff_valid === 1'b1 && bus.coeff_ready === 1'b1) begin
      beat_t e;
      if (sb.size() == 0) chk("unexpected_beat", 32'(bus.coeff_idx), 32'hFFFF);
      else begin
        e = sb.pop_front();
        chk("beat_data", 32'(bus.coeff_data), 32'(e.d));
        chk("beat_idx", 32'(bus.coeff_idx), 32'(e.i));
        chk("beat_last", 32'(bus.coeff_last), 32'(e.l));
      end
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      chk("done_busy", 32'(bus.busy), 1);
    end
  end

  task automatic wr(input int a, input int v, input bit exp_err);
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.wr_addr = 3'(a); bus.wr_data = 16'(v);
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    if (!exp_err) mdl[a] = 16'(v);
    @(negedge clk);
    chk("wr_err_idle", 32'(bus.wr_err), 32'(exp_err));
  endtask

  task automatic run(input int n, input bit d, input bit wr_same, input int wa, input int wd,
                     input bit mid_wr, input bit mid_start);
    int  nc, bc;
    bit  seen;
    nc = n > 8 ? 8 : n;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.term_cnt = 4'(n); bus.desc = d;
    if (wr_same) begin
      bus.wr_en = 1'b1; bus.wr_addr = 3'(wa); bus.wr_data = 16'(wd);
      mdl[wa] = 16'(wd);
    end
    for (int k = 0; k < nc; k++) begin
      int ix;
      ix = d ? nc - 1 - k : k;
      sb.push_back(beat_t'{d: mdl[ix], i: 3'(ix), l: k == nc - 1});
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.wr_en = 1'b0;
    bc = 0; seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("first_valid", 32'(bus.coeff_valid), 32'(nc > 0));
        if (wr_same) chk("wr_err_same", 32'(bus.wr_err), 0);
        if (mid_wr && nc > 0) begin
          bus.wr_en = 1'b1; bus.wr_addr = 3'($urandom_range(0, 7)); bus.wr_data = 16'hBEEF;
        end
        if (mid_start && nc > 1) begin
          bus.start = 1'b1; bus.term_cnt = 4'd3; bus.desc = ~d;
        end
      end
      if (c == 1) begin
        if (mid_wr && nc > 0) begin bus.wr_en = 1'b0; chk("wr_err_busy", 32'(bus.wr_err), 1); end
        bus.start = 1'b0;
      end
      if (bus.busy === 1'b1) bc++;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        if (mid_start && nc > 1) begin bus.start = 1'b1; bus.term_cnt = 4'd5; end
      end
    end
    chk("done_seen", 32'(seen), 1);
    if (rdy_mode == 0) chk("busy_cycles", 32'(bc), 32'(nc + 1));
    chk("sb_empty", 32'(sb.size()), 0);
    if (mid_start && nc > 1) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk("start_in_done_ignored", 32'(bus.busy), 0);
      chk("no_valid_after_done", 32'(bus.coeff_valid), 0);
    end
    sb.delete();
  endtask

  task automatic reset_mid_stream();
    int dc;
    rdy_mode = 3;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.term_cnt = 4'd8; bus.desc = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("stalled_valid", 32'(bus.coeff_valid), 1);
    chk("stalled_idx", 32'(bus.coeff_idx), 0);
    dc = done_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(bus.coeff_valid), 0);
    chk("rst_mid_busy", 32'(bus.busy), 0);
    chk("rst_mid_done", 32'(bus.done), 0);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_done", 32'(done_cnt), 32'(dc));
    rdy_mode = 0;
  endtask

  initial begin
    mdl = '{16'h7FFF, 16'hC000, 16'h2AAA, 16'hA000, 16'h1999, 16'h1555, 16'h1249, 16'h1000};
    rst = 1'b1;
    bus.start = 1'b0; bus.term_cnt = '0; bus.desc = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.coeff_valid), 0);
    chk("rst_last", 32'(bus.coeff_last), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_wr_err", 32'(bus.wr_err), 0);
    chk("rst_data", 32'(bus.coeff_data), 0);
    chk("rst_idx", 32'(bus.coeff_idx), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 0;
    run(8, 0, 0, 0, 0, 0, 0);
    rdy_mode = 2; pat = 0;
    run(4, 1, 0, 0, 0, 0, 0);
    rdy_mode = 0;
    run(0, 0, 0, 0, 0, 0, 0);
    wr(2, 16'h1234, 0);
    run(3, 0, 0, 0, 0, 0, 0);
    run(5, 0, 0, 0, 0, 1, 0);
    run(8, 0, 0, 0, 0, 0, 0);
    reset_mid_stream();
    run(8, 1, 0, 0, 0, 0, 0);
    run(8, 0, 0, 0, 0, 0, 1);
    run(15, 0, 0, 0, 0, 0, 0);
    run(6, 0, 1, 4, 16'h5A5A, 0, 0);
    for (int t = 0; t < 30; t++) begin
      int n;
      n = $urandom_range(0, 15);
      rdy_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) wr($urandom_range(0, 7), $urandom_range(0, 16'hFFFF), 0);
      run(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), $urandom_range(0, 7),
          $urandom_range(0, 16'hFFFF), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
